// File: rtl/orion_sync_mux.sv
// orion_sync_mux: clocked two-input merge for 2-phase bundled-data channels.
// A select token chooses whether the B (sel=1) or C (sel=0) data token is
// forwarded onto output channel A. All incoming reqs/acks are synchronized
// before use; all outgoing handshake lines and the data word are registered.
module orion_sync_mux #(
   parameter int   WIDTH       = 1,
   parameter int   SYNC_STAGES = 2,
   parameter logic PA_INIT     = 1'b0,
   parameter logic PB_INIT     = 1'b0,
   parameter logic PC_INIT     = 1'b0,
   parameter logic PS_INIT     = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inSel_req,
   output logic             inSel_ack,
   input  logic             inSel_data,
   input  logic             inB_req,
   output logic             inB_ack,
   input  logic [WIDTH-1:0] inB_data,
   input  logic             inC_req,
   output logic             inC_ack,
   input  logic [WIDTH-1:0] inC_data,
   output logic             outA_req,
   input  logic             outA_ack,
   output logic [WIDTH-1:0] outA_data
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } stateT;

   // Synchronizer chains; index 0 is the capture flop, the top index feeds logic
   logic [SYNC_STAGES-1:0] r_syncS;
   logic [SYNC_STAGES-1:0] r_syncB;
   logic [SYNC_STAGES-1:0] r_syncC;
   logic [SYNC_STAGES-1:0] r_syncA;

   logic w_sS;
   logic w_sB;
   logic w_sC;
   logic w_sA;

   // Registered state and outputs
   stateT            r_state;
   logic             r_sel;
   logic             r_outReq;
   logic             r_selAck;
   logic             r_bAck;
   logic             r_cAck;
   logic [WIDTH-1:0] r_outData;

   // Next-state values computed by the combinational FSM process
   stateT            w_stateNext;
   logic             w_selNext;
   logic             w_outReqNext;
   logic             w_selAckNext;
   logic             w_bAckNext;
   logic             w_cAckNext;
   logic [WIDTH-1:0] w_outDataNext;

   logic w_selPending;
   logic w_bPending;
   logic w_cPending;
   logic w_go;

   // Select request synchronizer; resets to the select ack's init so no token is seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_syncS <= {SYNC_STAGES{PS_INIT}};
      else       r_syncS <= {r_syncS[SYNC_STAGES-2:0], inSel_req};
   end

   // B request synchronizer; resets to the B ack's init so no token is seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_syncB <= {SYNC_STAGES{PB_INIT}};
      else       r_syncB <= {r_syncB[SYNC_STAGES-2:0], inB_req};
   end

   // C request synchronizer; resets to the C ack's init so no token is seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_syncC <= {SYNC_STAGES{PC_INIT}};
      else       r_syncC <= {r_syncC[SYNC_STAGES-2:0], inC_req};
   end

   // Output acknowledge synchronizer; resets to the A req's init so no ack is seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_syncA <= {SYNC_STAGES{PA_INIT}};
      else       r_syncA <= {r_syncA[SYNC_STAGES-2:0], outA_ack};
   end

   assign w_sS = r_syncS[SYNC_STAGES-1];
   assign w_sB = r_syncB[SYNC_STAGES-1];
   assign w_sC = r_syncC[SYNC_STAGES-1];
   assign w_sA = r_syncA[SYNC_STAGES-1];

   // A channel holds a token whenever its synchronized req differs from our ack.
   // Data is only looked at once the matching req token is visible, so the
   // bundled-data lines have long since settled.
   assign w_selPending = (w_sS != r_selAck);
   assign w_bPending   = (w_sB != r_bAck);
   assign w_cPending   = (w_sC != r_cAck);
   assign w_go         = w_selPending && (inSel_data ? w_bPending : w_cPending);

   // State and output registers; reset drops any in-flight token
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sel     <= 1'b0;
         r_outReq  <= PA_INIT;
         r_selAck  <= PS_INIT;
         r_bAck    <= PB_INIT;
         r_cAck    <= PC_INIT;
         r_outData <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_sel     <= w_selNext;
         r_outReq  <= w_outReqNext;
         r_selAck  <= w_selAckNext;
         r_bAck    <= w_bAckNext;
         r_cAck    <= w_cAckNext;
         r_outData <= w_outDataNext;
      end
   end

   // Next-state logic: IDLE launches a token on A once select and the chosen
   // input are both pending; WAIT completes both input handshakes when A returns.
   // An A ack arriving in IDLE is a downstream error and is simply ignored.
   always_comb begin
      w_stateNext   = r_state;
      w_selNext     = r_sel;
      w_outReqNext  = r_outReq;
      w_selAckNext  = r_selAck;
      w_bAckNext    = r_bAck;
      w_cAckNext    = r_cAck;
      w_outDataNext = r_outData;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_outDataNext = inSel_data ? inB_data : inC_data;
               w_outReqNext  = ~r_outReq;
               w_selNext     = inSel_data;
               w_stateNext   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_sA == r_outReq) begin
               w_selAckNext = ~r_selAck;
               if (r_sel) w_bAckNext = ~r_bAck;
               else       w_cAckNext = ~r_cAck;
               w_stateNext  = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   assign outA_req  = r_outReq;
   assign inSel_ack = r_selAck;
   assign inB_ack   = r_bAck;
   assign inC_ack   = r_cAck;
   assign outA_data = r_outData;

endmodule

// File: tb/tb_orion_sync_mux.sv
// Testbench for orion_sync_mux: directed vector table, hand-written corner
// sequences and a randomized token stress against a queue-based model.
module tb_orion_sync_mux;

   localparam int WIDTH = 8;
   localparam int SYNC  = 2;
   localparam int LAT   = SYNC + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             inSel_req;
   logic             inSel_ack;
   logic             inSel_data;
   logic             inB_req;
   logic             inB_ack;
   logic [WIDTH-1:0] inB_data;
   logic             inC_req;
   logic             inC_ack;
   logic [WIDTH-1:0] inC_data;
   logic             outA_req;
   logic             outA_ack;
   logic [WIDTH-1:0] outA_data;

   int total = 0;
   int bad   = 0;

   // Handshake levels the bench expects the DUT to hold
   logic modelReq;
   logic modelSelAck;
   logic modelBAck;
   logic modelCAck;

   // Every observed ack edge, used to prove each token is acked exactly once
   int selToggles = 0;
   int bToggles   = 0;
   int cToggles   = 0;

   typedef struct {
      logic             sendB;
      logic             sendC;
      logic [WIDTH-1:0] bData;
      logic [WIDTH-1:0] cData;
      logic             sel;
      logic [WIDTH-1:0] expData;
      logic             expBToggle;
      logic             expCToggle;
   } vecT;

   vecT vecs[4];

   orion_sync_mux #(
      .WIDTH(WIDTH), .SYNC_STAGES(SYNC),
      .PA_INIT(1'b0), .PB_INIT(1'b0), .PC_INIT(1'b0), .PS_INIT(1'b0)
   ) dut (
      .clk(clk), .reset(reset),
      .inSel_req(inSel_req), .inSel_ack(inSel_ack), .inSel_data(inSel_data),
      .inB_req(inB_req), .inB_ack(inB_ack), .inB_data(inB_data),
      .inC_req(inC_req), .inC_ack(inC_ack), .inC_data(inC_data),
      .outA_req(outA_req), .outA_ack(outA_ack), .outA_data(outA_data)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Ack edge counters
   always @(inSel_ack) selToggles++;
   always @(inB_ack) bToggles++;
   always @(inC_ack) cToggles++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkAcks(input string name);
      checkOutput({name, " selAck"}, {31'd0, inSel_ack}, {31'd0, modelSelAck});
      checkOutput({name, " bAck"},   {31'd0, inB_ack},   {31'd0, modelBAck});
      checkOutput({name, " cAck"},   {31'd0, inC_ack},   {31'd0, modelCAck});
   endtask

   // One directed token: inject, check forward latency/data, return ack, check return latency
   task automatic applyStimulus(input vecT v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.sendB) begin
         inB_data = v.bData;
         inB_req  = ~inB_req;
      end
      if (v.sendC) begin
         inC_data = v.cData;
         inC_req  = ~inC_req;
      end
      inSel_data = v.sel;
      inSel_req  = ~inSel_req;
      cycles(LAT - 1);
      checkOutput({tag, " req early"}, {31'd0, outA_req}, {31'd0, modelReq});
      cycles(1);
      modelReq = ~modelReq;
      checkOutput({tag, " req"}, {31'd0, outA_req}, {31'd0, modelReq});
      checkOutput({tag, " data"}, {24'd0, outA_data}, {24'd0, v.expData});
      outA_ack = ~outA_ack;
      cycles(LAT - 1);
      checkAcks({tag, " early"});
      cycles(1);
      modelSelAck = ~modelSelAck;
      if (v.expBToggle) modelBAck = ~modelBAck;
      if (v.expCToggle) modelCAck = ~modelCAck;
      checkAcks(tag);
   endtask

   task automatic resetAll(input int holdCycles);
      reset      = 1'b1;
      inSel_req  = 1'b0;
      inB_req    = 1'b0;
      inC_req    = 1'b0;
      outA_ack   = 1'b0;
      modelReq    = 1'b0;
      modelSelAck = 1'b0;
      modelBAck   = 1'b0;
      modelCAck   = 1'b0;
      cycles(holdCycles);
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      inSel_data = 1'b0;
      inB_data   = '0;
      inC_data   = '0;

      vecs[0] = '{sendB:1'b1, sendC:1'b0, bData:8'hA5, cData:8'h00, sel:1'b1,
                  expData:8'hA5, expBToggle:1'b1, expCToggle:1'b0};
      vecs[1] = '{sendB:1'b1, sendC:1'b1, bData:8'h11, cData:8'h22, sel:1'b0,
                  expData:8'h22, expBToggle:1'b0, expCToggle:1'b1};
      vecs[2] = '{sendB:1'b0, sendC:1'b0, bData:8'h00, cData:8'h00, sel:1'b1,
                  expData:8'h11, expBToggle:1'b1, expCToggle:1'b0};
      vecs[3] = '{sendB:1'b0, sendC:1'b1, bData:8'h00, cData:8'h3C, sel:1'b0,
                  expData:8'h3C, expBToggle:1'b0, expCToggle:1'b1};

      // Reset defaults and quiet idle period
      @(negedge clk);
      resetAll(3);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("idle%0d", i),
                     {20'd0, outA_req, inSel_ack, inB_ack, inC_ack, outA_data},
                     32'd0);
         cycles(1);
      end

      // Directed vector table
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

      // Select pending while C stays idle must not launch anything
      inSel_data = 1'b0;
      inSel_req  = ~inSel_req;
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         checkOutput($sformatf("selwait%0d", i), {31'd0, outA_req}, {31'd0, modelReq});
      end
      inC_data = 8'h5A;
      inC_req  = ~inC_req;
      cycles(LAT - 1);
      checkOutput("selwait req early", {31'd0, outA_req}, {31'd0, modelReq});
      cycles(1);
      modelReq = ~modelReq;
      checkOutput("selwait req", {31'd0, outA_req}, {31'd0, modelReq});
      checkOutput("selwait data", {24'd0, outA_data}, 32'h5A);
      outA_ack = ~outA_ack;
      cycles(LAT);
      modelSelAck = ~modelSelAck;
      modelCAck   = ~modelCAck;
      checkAcks("selwait");

      // Reset while waiting on A: everything returns to init immediately
      inB_data   = 8'h77;
      inB_req    = ~inB_req;
      inSel_data = 1'b1;
      inSel_req  = ~inSel_req;
      cycles(LAT);
      modelReq = ~modelReq;
      checkOutput("midwait req", {31'd0, outA_req}, {31'd0, modelReq});
      checkOutput("midwait data", {24'd0, outA_data}, 32'h77);
      #2;
      reset      = 1'b1;
      inSel_req  = 1'b0;
      inB_req    = 1'b0;
      inC_req    = 1'b0;
      outA_ack   = 1'b0;
      #1;
      checkOutput("midwait async reset",
                  {20'd0, outA_req, inSel_ack, inB_ack, inC_ack, outA_data}, 32'd0);
      modelReq = 1'b0; modelSelAck = 1'b0; modelBAck = 1'b0; modelCAck = 1'b0;
      cycles(2);
      reset = 1'b0;
      cycles(1);
      outA_ack = 1'b1;
      cycles(10);
      checkOutput("stray ack outputs",
                  {28'd0, outA_req, inSel_ack, inB_ack, inC_ack}, 32'd0);

      // Clean restart for the randomized stress
      resetAll(2);
      cycles(LAT);

      for (int t = 0; t < 200; t++) begin
         logic             s;
         logic             pendB;
         logic             pendC;
         logic [WIDTH-1:0] expQ[$];
         int               s0, b0, c0, n;
         s  = 1'($urandom % 2);
         s0 = selToggles; b0 = bToggles; c0 = cToggles;
         pendB = (inB_req != modelBAck);
         pendC = (inC_req != modelCAck);
         // Occasionally park a token on the channel that is not selected
         if ($urandom % 4 == 0) begin
            if (s && !pendC) begin
               inC_data = 8'($urandom);
               inC_req  = ~inC_req;
               pendC    = 1'b1;
            end else if (!s && !pendB) begin
               inB_data = 8'($urandom);
               inB_req  = ~inB_req;
               pendB    = 1'b1;
            end
         end
         inSel_data = s;
         if ($urandom % 2 == 0) begin
            inSel_req = ~inSel_req;
            cycles($urandom_range(0, 5));
         end else begin
            cycles(0);
         end
         if (s && !pendB) begin
            inB_data = 8'($urandom);
            inB_req  = ~inB_req;
         end else if (!s && !pendC) begin
            inC_data = 8'($urandom);
            inC_req  = ~inC_req;
         end
         if (inSel_req == modelSelAck) begin
            cycles($urandom_range(0, 5));
            inSel_req = ~inSel_req;
         end
         expQ.push_back(s ? inB_data : inC_data);

         n = 0;
         while (outA_req == modelReq && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput($sformatf("stress%0d req timeout", t), (n < 100) ? 32'd1 : 32'd0, 32'd1);
         modelReq = ~modelReq;
         checkOutput($sformatf("stress%0d data", t), {24'd0, outA_data}, {24'd0, expQ.pop_front()});

         cycles($urandom_range(0, 15));
         outA_ack = ~outA_ack;
         n = 0;
         while (inSel_ack == modelSelAck && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput($sformatf("stress%0d ack timeout", t), (n < 100) ? 32'd1 : 32'd0, 32'd1);
         modelSelAck = ~modelSelAck;
         if (s) modelBAck = ~modelBAck;
         else   modelCAck = ~modelCAck;
         cycles(2);
         checkAcks($sformatf("stress%0d", t));
         checkOutput($sformatf("stress%0d ack edges", t),
                     {selToggles - s0, bToggles - b0, cToggles - c0} ,
                     {32'd1, s ? 32'd1 : 32'd0, s ? 32'd0 : 32'd1});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
